// File: rtl/l1i_pkg.sv
// rtl/l1i_pkg.sv - shared types and width helpers for the direct-mapped L1 instruction cache
package l1i_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_REFILL = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam int WB_BL_W = 10;

    function automatic int woff_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_len, input int sets, input int line_words);
        return addr_len - $clog2(sets) - $clog2(line_words) - 2;
    endfunction

endpackage

// File: rtl/l1i_valid_array.sv
// rtl/l1i_valid_array.sv - per-line valid flops with single set and global clear
module l1i_valid_array #(
    parameter int SETS    = 64,
    parameter int INDEX_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set_i,
    input  logic [INDEX_W-1:0] set_idx_i,
    input  logic               clr_all_i,
    input  logic [INDEX_W-1:0] rd_idx_i,
    output logic               rd_valid_o
);

    logic [SETS-1:0] valid_q;

    // Clear-all takes priority so a flush racing a refill completion leaves the line invalid
    always_ff @(posedge clk) begin
        if (rst || clr_all_i) begin
            valid_q <= '0;
        end else if (set_i) begin
            valid_q[set_idx_i] <= 1'b1;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/l1icache_dm_param.sv
// rtl/l1icache_dm_param.sv - parametrised direct-mapped L1 instruction cache with burst refill
module l1icache_dm_param
    import l1i_pkg::*;
#(
    parameter int ADDR_LEN   = 32,
    parameter int DATA_LEN   = 32,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    localparam int WOFF_W    = woff_w(LINE_WORDS),
    localparam int OFFSET_W  = WOFF_W + 2,
    localparam int INDEX_W   = index_w(SETS),
    localparam int TAG_W     = tag_w(ADDR_LEN, SETS, LINE_WORDS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [ADDR_LEN-1:0]       req_addr_i,
    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic [DATA_LEN-1:0]       ld_data_o,
    output logic [ADDR_LEN-1:0]       resp_addr_o,
    input  logic                      flush_i,
    output logic                      tag_csb_o,
    output logic                      tag_web_o,
    output logic [INDEX_W-1:0]        tag_addr_o,
    output logic [TAG_W-1:0]          tag_wdata_o,
    input  logic [TAG_W-1:0]          tag_rdata_i,
    output logic                      data_csb_o,
    output logic                      data_web_o,
    output logic [INDEX_W+WOFF_W-1:0] data_addr_o,
    output logic [DATA_LEN-1:0]       data_wdata_o,
    input  logic [DATA_LEN-1:0]       data_rdata_i,
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [ADDR_LEN-1:0]       wb_adr_o,
    output logic [WB_BL_W-1:0]        wb_bl_o,
    input  logic                      wb_ack_i,
    input  logic [DATA_LEN-1:0]       wb_dat_i
);

    state_e              state_q, state_d;
    logic [ADDR_LEN-1:0] addr_q;
    logic [WOFF_W-1:0]   cnt_q;
    logic [DATA_LEN-1:0] resp_q;
    logic                flush_pend_q;

    logic [INDEX_W-1:0]  req_idx, idx_q;
    logic [WOFF_W-1:0]   req_word, word_q;
    logic [TAG_W-1:0]    tag_q;
    logic                req_hs, valid_rd, hit, refill_ack, last_beat, clr_all;

    assign req_idx  = req_addr_i[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign req_word = req_addr_i[OFFSET_W-1:2];
    assign idx_q    = addr_q[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign word_q   = addr_q[OFFSET_W-1:2];
    assign tag_q    = addr_q[ADDR_LEN-1:OFFSET_W+INDEX_W];

    // Requests are refused during reset and while any flush is outstanding
    assign req_ready_o = (state_q == ST_IDLE) & ~flush_i & ~flush_pend_q & ~rst;
    assign req_hs      = req_valid_i & req_ready_o;
    assign hit         = valid_rd & (tag_rdata_i == tag_q);
    assign refill_ack  = (state_q == ST_REFILL) & wb_ack_i;
    assign last_beat   = refill_ack & (cnt_q == '1);
    assign clr_all     = (state_q == ST_IDLE) & (flush_i | flush_pend_q);

    l1i_valid_array #(
        .SETS    (SETS),
        .INDEX_W (INDEX_W)
    ) u_valid (
        .clk        (clk),
        .rst        (rst),
        .set_i      (last_beat),
        .set_idx_i  (idx_q),
        .clr_all_i  (clr_all),
        .rd_idx_i   (idx_q),
        .rd_valid_o (valid_rd)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_hs) state_d = ST_LOOKUP;
            ST_LOOKUP: state_d = hit ? ST_RESP : ST_REFILL;
            ST_REFILL: if (last_beat) state_d = ST_RESP;
            ST_RESP:   if (resp_ready_i) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // SRAM strobes: lookup read on handshake, data write per beat, tag write on the final beat
    always_comb begin
        tag_csb_o    = 1'b1;
        tag_web_o    = 1'b1;
        tag_addr_o   = '0;
        tag_wdata_o  = '0;
        data_csb_o   = 1'b1;
        data_web_o   = 1'b1;
        data_addr_o  = '0;
        data_wdata_o = '0;
        if (req_hs) begin
            tag_csb_o   = 1'b0;
            tag_addr_o  = req_idx;
            data_csb_o  = 1'b0;
            data_addr_o = {req_idx, req_word};
        end else if (refill_ack) begin
            data_csb_o   = 1'b0;
            data_web_o   = 1'b0;
            data_addr_o  = {idx_q, cnt_q};
            data_wdata_o = wb_dat_i;
            if (last_beat) begin
                tag_csb_o   = 1'b0;
                tag_web_o   = 1'b0;
                tag_addr_o  = idx_q;
                tag_wdata_o = tag_q;
            end
        end
    end

    assign wb_cyc_o     = (state_q == ST_REFILL);
    assign wb_stb_o     = wb_cyc_o;
    assign wb_we_o      = 1'b0;
    assign wb_adr_o     = wb_cyc_o ? {addr_q[ADDR_LEN-1:OFFSET_W], {OFFSET_W{1'b0}}} : '0;
    assign wb_bl_o      = wb_cyc_o ? WB_BL_W'(LINE_WORDS) : '0;
    assign resp_valid_o = (state_q == ST_RESP);
    assign ld_data_o    = resp_q;
    assign resp_addr_o  = addr_q;

    // Request address, beat counter, response buffer and deferred-flush flag
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            cnt_q        <= '0;
            resp_q       <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            if (req_hs) begin
                addr_q <= req_addr_i;
                cnt_q  <= '0;
            end
            if ((state_q == ST_LOOKUP) && hit) begin
                resp_q <= data_rdata_i;
            end
            if (refill_ack) begin
                cnt_q <= cnt_q + WOFF_W'(1);
                if (cnt_q == word_q) begin
                    resp_q <= wb_dat_i;
                end
            end
            if (state_q == ST_IDLE) begin
                flush_pend_q <= 1'b0;
            end else if (flush_i) begin
                flush_pend_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_l1icache_dm_param.sv
// tb/tb_l1icache_dm_param.sv - scoreboard bench for the direct-mapped L1 instruction cache
module tb_l1icache_dm_param;

    localparam int TAG_W = 22;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b1;
    logic [31:0] ld_data_o;
    logic [31:0] resp_addr_o;
    logic        flush_i = 1'b0;
    logic        tag_csb_o, tag_web_o;
    logic [5:0]  tag_addr_o;
    logic [TAG_W-1:0] tag_wdata_o;
    logic [TAG_W-1:0] tag_rdata_i = '0;
    logic        data_csb_o, data_web_o;
    logic [7:0]  data_addr_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i = '0;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o;
    logic [9:0]  wb_bl_o;
    logic        wb_ack_i = 1'b0;
    logic [31:0] wb_dat_i = '0;

    l1icache_dm_param dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .ld_data_o    (ld_data_o),
        .resp_addr_o  (resp_addr_o),
        .flush_i      (flush_i),
        .tag_csb_o    (tag_csb_o),
        .tag_web_o    (tag_web_o),
        .tag_addr_o   (tag_addr_o),
        .tag_wdata_o  (tag_wdata_o),
        .tag_rdata_i  (tag_rdata_i),
        .data_csb_o   (data_csb_o),
        .data_web_o   (data_web_o),
        .data_addr_o  (data_addr_o),
        .data_wdata_o (data_wdata_o),
        .data_rdata_i (data_rdata_i),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_we_o      (wb_we_o),
        .wb_adr_o     (wb_adr_o),
        .wb_bl_o      (wb_bl_o),
        .wb_ack_i     (wb_ack_i),
        .wb_dat_i     (wb_dat_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        int          hs;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc_cnt = 0;
    int          beat = 0;
    int          ack_total = 0;
    int          refills = 0;
    logic [31:0] bus_base = '0;
    logic [31:0] last_adr = '0;
    logic [9:0]  last_bl = '0;
    logic [TAG_W-1:0] tag_mem [64];
    logic [31:0] data_mem [256];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: actual=timeout required=event", name);
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // 1-cycle SRAM macro models
    always @(posedge clk) begin
        if (!tag_csb_o) begin
            if (!tag_web_o) tag_mem[tag_addr_o] <= tag_wdata_o;
            else            tag_rdata_i <= tag_mem[tag_addr_o];
        end
        if (!data_csb_o) begin
            if (!data_web_o) data_mem[data_addr_o] <= data_wdata_o;
            else             data_rdata_i <= data_mem[data_addr_o];
        end
    end

    // Bus slave: four back-to-back beats of bus_base+n per cycle; restarts when cyc drops
    always @(posedge clk) begin
        if (wb_cyc_o && wb_stb_o && beat < 4) begin
            wb_ack_i  <= 1'b1;
            wb_dat_i  <= bus_base + 32'(beat);
            beat      <= beat + 1;
            ack_total <= ack_total + 1;
        end else begin
            wb_ack_i <= 1'b0;
            if (!wb_cyc_o) beat <= 0;
        end
    end

    // Refill monitor: record burst address and length at the start of each bus cycle
    initial begin
        logic cyc_prev;
        cyc_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (wb_cyc_o && !cyc_prev) begin
                refills++;
                last_adr = wb_adr_o;
                last_bl  = wb_bl_o;
            end
            cyc_prev = wb_cyc_o;
        end
    end

    // Response monitor: compare against the scoreboard head when the DUT presents a response
    initial begin
        bit seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_valid_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", {32'h0, ld_data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    if (!seen && q[0].lat >= 0) chk("hit_latency", 64'(cyc_cnt - q[0].hs), 64'(q[0].lat));
                    seen = 1'b1;
                    if (resp_ready_i) begin
                        chk("ld_data", ld_data_o, q[0].data);
                        chk("resp_addr", resp_addr_o, q[0].addr);
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the request handshake
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input int lat, input bit push);
        int n;
        n = 0;
        req_addr_i  = a;
        req_valid_i = 1'b1;
        #1;
        while (!req_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_o) begin
            bound_fail("req_handshake");
            req_valid_i = 1'b0;
            return;
        end
        if (push) q.push_back('{a, d, lat, cyc_cnt});
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
    endtask

    // Returns at the negedge of the first cycle after the response handshake
    task automatic wait_resp();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            bound_fail("resp_wait");
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_beat(input int b);
        int n;
        n = 0;
        while (beat < b && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (beat < b) bound_fail("beat_wait");
    endtask

    task automatic chk_reset_outputs(input string tagname);
        chk({tagname, "_resp_valid"}, resp_valid_o, 0);
        chk({tagname, "_req_ready"}, req_ready_o, 0);
        chk({tagname, "_wb_cyc"}, {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
        chk({tagname, "_wb_adr_bl"}, {wb_adr_o, 22'h0, wb_bl_o}, 0);
        chk({tagname, "_sram_ctl"}, {tag_csb_o, tag_web_o, data_csb_o, data_web_o}, 4'hF);
        chk({tagname, "_ld_data"}, ld_data_o, 0);
        chk({tagname, "_resp_addr"}, resp_addr_o, 0);
    endtask

    initial begin
        int r0;
        int a0;
        for (int i = 0; i < 64; i++) tag_mem[i] = '0;
        for (int i = 0; i < 256; i++) data_mem[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_req_ready", req_ready_o, 1);

        // 1: cold miss, critical word is beat 1
        bus_base = 32'hA0;
        issue(32'h0000_1234, 32'hA1, -1, 1'b1);
        wait_resp();
        chk("t1_refills", 64'(refills), 1);
        chk("t1_wb_adr", last_adr, 32'h0000_1230);
        chk("t1_wb_bl", last_bl, 4);

        // 2: hit on the same line, no bus traffic
        r0 = refills;
        issue(32'h0000_123C, 32'hA3, 2, 1'b1);
        wait_resp();
        chk("t2_no_refill", 64'(refills), 64'(r0));

        // 3: conflicting tag on index 0x23 evicts, then the original line misses
        bus_base = 32'hB0;
        issue(32'h0000_1634, 32'hB1, -1, 1'b1);
        wait_resp();
        chk("t3_refills_a", 64'(refills), 64'(r0 + 1));
        chk("t3_wb_adr_a", last_adr, 32'h0000_1630);
        bus_base = 32'hC0;
        issue(32'h0000_1234, 32'hC1, -1, 1'b1);
        wait_resp();
        chk("t3_refills_b", 64'(refills), 64'(r0 + 2));
        chk("t3_wb_adr_b", last_adr, 32'h0000_1230);
        issue(32'h0000_1230, 32'hC0, 2, 1'b1);
        wait_resp();
        chk("t3_hit_word0", 64'(refills), 64'(r0 + 2));

        // 4: back-pressured hit holds its response steady
        resp_ready_i = 1'b0;
        issue(32'h0000_1238, 32'hC2, 2, 1'b1);
        begin
            int n;
            n = 0;
            while (!resp_valid_o && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!resp_valid_o) bound_fail("t4_resp_valid");
        end
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", resp_valid_o, 1);
            chk("t4_hold_data", ld_data_o, 32'hC2);
            chk("t4_hold_addr", resp_addr_o, 32'h0000_1238);
            chk("t4_hold_req_ready", req_ready_o, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 resp_ready_i = 1'b1;
        wait_resp();

        // 5: flush in the middle of a refill still answers, then everything misses
        r0 = refills;
        bus_base = 32'hD0;
        issue(32'h0000_2008, 32'hD2, -1, 1'b1);
        wait_beat(2);
        @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        wait_resp();
        chk("t5_pend_req_ready", req_ready_o, 0);
        @(negedge clk);
        chk("t5_after_req_ready", req_ready_o, 1);
        bus_base = 32'hE0;
        issue(32'h0000_2008, 32'hE2, -1, 1'b1);
        wait_resp();
        chk("t5_rerequest_miss", 64'(refills), 64'(r0 + 2));
        bus_base = 32'hF0;
        issue(32'h0000_1234, 32'hF1, -1, 1'b1);
        wait_resp();
        chk("t5_other_line_miss", 64'(refills), 64'(r0 + 3));

        // 5b: flush and request together in IDLE: flush wins
        req_addr_i  = 32'h0000_1234;
        req_valid_i = 1'b1;
        flush_i     = 1'b1;
        #1;
        chk("t5b_req_ready", req_ready_o, 0);
        chk("t5b_no_tag_read", tag_csb_o, 1);
        @(posedge clk);
        #1;
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("t5b_state_idle", {resp_valid_o, wb_cyc_o}, 0);
        bus_base = 32'h10;
        issue(32'h0000_1234, 32'h11, -1, 1'b1);
        wait_resp();
        chk("t5b_flushed_miss", 64'(refills), 64'(r0 + 4));

        // 6: reset after two beats aborts the burst; the line refills from scratch afterwards
        bus_base = 32'h50;
        issue(32'h0000_3000, 32'h0, -1, 1'b0);
        wait_beat(3);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("t6");
        rst = 1'b0;
        @(negedge clk);
        r0 = refills;
        a0 = ack_total;
        bus_base = 32'h60;
        issue(32'h0000_3004, 32'h61, -1, 1'b1);
        wait_resp();
        chk("t6_refills", 64'(refills), 64'(r0 + 1));
        chk("t6_wb_adr", last_adr, 32'h0000_3000);
        chk("t6_beats", 64'(ack_total - a0), 4);
        issue(32'h0000_300C, 32'h63, 2, 1'b1);
        wait_resp();
        chk("t6_hit_after", 64'(refills), 64'(r0 + 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

endmodule
